// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream
//   Streaming 2x2 / stride-2 max-pooling stage. Consumes one signed fixed-point
//   pixel per handshake in raster order for an IMG_W x IMG_H map and emits the
//   (IMG_W/2) x (IMG_H/2) pooled map in raster order. Partial maxima of the even
//   row are kept in a line buffer of IMG_W/2 words; no frame buffering.
//
// Parameters
//   N      data word width (two's complement)
//   Q      fractional bits (format tag only; the max does not depend on it)
//   IMG_W  input width in pixels (even, >= 2)
//   IMG_H  input height in pixels (even, >= 2)
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active low
//   in_valid   in_data holds a pixel
//   in_ready   block accepts in_data this cycle
//   in_data    pixel, signed Q(N-Q).Q
//   out_valid  out_data holds a pooled result
//   out_ready  consumer accepts out_data this cycle
//   out_data   pooled maximum, same format as input
//   out_last   with out_valid: last pooled pixel of the frame
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. A producer holding valid keeps its data stable until the transfer;
// ready may depend combinationally on the other side, valid never does.

module maxpool2x2_stream #(
    parameter int N     = 16,
    parameter int Q     = 12,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_last
);

    localparam int CW       = $clog2(IMG_W);
    localparam int RW       = $clog2(IMG_H);
    localparam int LB_DEPTH = IMG_W / 2;
    localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    // Elaboration-time guard against geometries the pairing scheme cannot handle.
    generate
        if ((IMG_W < 2) || (IMG_W % 2 != 0) || (IMG_H < 2) || (IMG_H % 2 != 0) || (Q >= N)) begin : g_bad_params
            $error("maxpool2x2_stream: IMG_W/IMG_H must be even and >= 2, Q < N");
        end
    endgenerate

    // Signed maximum; on a tie both operands are the same value.
    function automatic logic [N-1:0] smax(input logic [N-1:0] a, input logic [N-1:0] b);
        return ($signed(a) >= $signed(b)) ? a : b;
    endfunction

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [N-1:0]  pair_q, pair_d;
    logic          out_valid_q, out_valid_d;
    logic [N-1:0]  out_data_q, out_data_d;
    logic          out_last_q, out_last_d;

    // Line buffer: holds max of the two even-row pixels of each window column pair.
    logic [N-1:0]  lbuf_q [LB_DEPTH];
    logic          lbuf_we_d;
    logic [N-1:0]  lbuf_wdata_d;
    logic [AW-1:0] lb_addr;
    logic [N-1:0]  lb_rdata;

    logic acc;
    logic col_end;
    logic row_end;

    // The output register can take a new result when it is empty or being drained.
    assign in_ready = ~out_valid_q | out_ready;
    assign acc      = in_valid & in_ready;
    assign col_end  = (col_q == CW'(IMG_W - 1));
    assign row_end  = (row_q == RW'(IMG_H - 1));
    assign lb_addr  = AW'(col_q >> 1);
    assign lb_rdata = lbuf_q[lb_addr];

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        pair_d       = pair_q;
        out_valid_d  = out_valid_q & ~out_ready;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        lbuf_we_d    = 1'b0;
        lbuf_wdata_d = smax(pair_q, in_data);

        if (acc) begin
            // Window position is {row parity, col parity}.
            unique case ({row_q[0], col_q[0]})
                2'b00: pair_d = in_data;
                2'b01: lbuf_we_d = 1'b1;
                2'b10: pair_d = smax(lb_rdata, in_data);
                default: begin
                    // Bottom-right pixel closes the window; a load wins over a drain.
                    out_data_d  = smax(pair_q, in_data);
                    out_valid_d = 1'b1;
                    out_last_d  = row_end & col_end;
                end
            endcase

            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q       <= '0;
            row_q       <= '0;
            pair_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            pair_q      <= pair_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // Not reset: each entry is written on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (lbuf_we_d) begin
            lbuf_q[lb_addr] <= lbuf_wdata_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
module tb_maxpool2x2_stream;

    localparam int N = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic sel;   // 0: 4x4 instance active, 1: 28x28 instance active

    logic         in_valid, in_ready, out_valid, out_ready, out_last;
    logic [N-1:0] in_data, out_data;

    logic         in_valid_s, in_ready_s, out_valid_s, out_last_s;
    logic [N-1:0] out_data_s;
    logic         in_valid_b, in_ready_b, out_valid_b, out_last_b;
    logic [N-1:0] out_data_b;

    assign in_valid_s = in_valid & ~sel;
    assign in_valid_b = in_valid & sel;
    assign in_ready   = sel ? in_ready_b  : in_ready_s;
    assign out_valid  = sel ? out_valid_b : out_valid_s;
    assign out_data   = sel ? out_data_b  : out_data_s;
    assign out_last   = sel ? out_last_b  : out_last_s;

    maxpool2x2_stream #(.N(N), .Q(12), .IMG_W(4), .IMG_H(4)) u_small (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_s), .in_ready(in_ready_s), .in_data(in_data),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s), .out_last(out_last_s)
    );

    maxpool2x2_stream #(.N(N), .Q(12), .IMG_W(28), .IMG_H(28)) u_big (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .out_last(out_last_b)
    );

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int lat_cycle = -1;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: held low
    bit bubbles = 1'b0;
    bit bp_arm  = 1'b0;
    int bp_left = 0;
    logic [N-1:0] bp_data;

    logic [N:0]   exp_q[$];   // {last, data}
    logic [N-1:0] frame[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Max over each 2x2 window of the frame, in raster order of windows.
    function automatic void model_frame(input int w, input int h);
        logic signed [N-1:0] m;
        for (int r = 0; r < h; r += 2) begin
            for (int c = 0; c < w; c += 2) begin
                m = frame[r*w + c];
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++)
                        if ($signed(frame[(r+dr)*w + c + dc]) > m) m = frame[(r+dr)*w + c + dc];
                exp_q.push_back({(r == h-2) && (c == w-2), m});
            end
        end
    endfunction

    // ---------------- output ready control / stall checks ----------------
    always @(negedge clk) begin
        if (bp_arm && out_valid) begin
            bp_arm  = 1'b0;
            bp_left = 5;
            bp_data = out_data;
        end
        if (bp_left > 0) begin
            out_ready = 1'b0;
            bp_left--;
            #1;
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_out_data", out_data, bp_data);
        end else begin
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [N:0] e;
        #2;
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got 0x%0h last %0b expected none", out_data, out_last);
            end else begin
                e = exp_q.pop_front();
                check("out_data", out_data, e[N-1:0]);
                check("out_last", out_last, e[N]);
            end
        end
        if (lat_cycle == cyc) check("latency_valid", out_valid, 1);
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [N-1:0] d, input int idx, input int w);
        int tries = 0;
        bit done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (bubbles && $urandom_range(0, 1) == 0) begin
                in_valid = 1'b0;
                in_data  = N'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = d;
            end
            #2;
            if (in_valid && in_ready) begin
                done = 1'b1;
                if (((idx / w) % 2 == 1) && ((idx % w) % 2 == 1)) lat_cycle = cyc + 1;
            end else if (++tries > 2000) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: pixel %0d not accepted, expected acceptance", idx);
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_frame(input int w, input int cnt);
        for (int i = 0; i < cnt; i++) send(frame[i], i, w);
    endtask

    task automatic ramp(input int base);
        frame.delete();
        for (int i = 0; i < 16; i++) frame.push_back(N'(base + i));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_in_ready", in_ready, 1);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b0;
        sel = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        sel = 1'b1;
        #1;
        check("init_big_out_valid", out_valid, 0);
        check("init_big_out_data", out_data, 0);
        sel = 1'b0;
        do_reset();

        // 1: ramp
        ramp(0);
        model_frame(4, 4);
        send_frame(4, 16);
        drain("t1_ramp_drained");

        // 2: signed compare
        frame.delete();
        for (int i = 0; i < 16; i++) frame.push_back(16'hF000);
        frame[0*4+0] = 16'hFFFF;
        frame[1*4+3] = 16'hFFFF;
        frame[3*4+0] = 16'hFFFF;
        frame[2*4+3] = 16'h1000;
        model_frame(4, 4);
        send_frame(4, 16);
        drain("t2_signed_drained");

        // 3: backpressure on the first result
        bp_arm = 1'b1;
        ramp(0);
        model_frame(4, 4);
        send_frame(4, 16);
        drain("t3_backpressure_drained");
        check("t3_stall_happened", bp_arm, 0);

        // 4: input bubbles
        bubbles = 1'b1;
        ramp(0);
        model_frame(4, 4);
        send_frame(4, 16);
        drain("t4_bubbles_drained");
        bubbles = 1'b0;

        // 5: reset mid-frame with a result pending
        ready_mode = 2;
        ramp(0);
        send_frame(4, 6);
        do_reset();
        ready_mode = 0;
        ramp(0);
        model_frame(4, 4);
        send_frame(4, 16);
        drain("t5_reset_midframe_drained");

        // 6: back-to-back frames
        ramp(0);
        model_frame(4, 4);
        send_frame(4, 16);
        ramp(16);
        model_frame(4, 4);
        send_frame(4, 16);
        drain("t6_back_to_back_drained");

        // 28x28 random frames with random bubbles and backpressure
        @(negedge clk);
        sel = 1'b1;
        do_reset();
        ready_mode = 1;
        bubbles = 1'b1;
        for (int f = 0; f < 2; f++) begin
            frame.delete();
            for (int i = 0; i < 28*28; i++) frame.push_back(N'($urandom));
            check("big_expected_count", exp_q.size() + 196, 196 * (1 + exp_q.size() / 196) + exp_q.size() % 196);
            model_frame(28, 28);
            send_frame(28, 28*28);
        end
        drain("big_random_drained");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
